// File: rtl/virgule_pkg.sv
// virgule_pkg: shared register offsets, timer control layout and bus lane merge helper
package virgule_pkg;
  localparam logic [2:0] TIMER_CTRL     = 3'd0;
  localparam logic [2:0] TIMER_PRESCALE = 3'd1;
  localparam logic [2:0] TIMER_COMPARE  = 3'd2;
  localparam logic [2:0] TIMER_COUNT    = 3'd3;
  localparam logic [2:0] TIMER_STATUS   = 3'd4;
  typedef struct packed {
    logic periodic;
    logic irq_en;
    logic enable;
  } timer_ctrl_t;
  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] merge_wstrobe(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] wstrobe);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = wstrobe[i] ? wdata[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/virgule_timer_prescaler.sv
// virgule_timer_prescaler: divides clk down to one tick every prescale+1 cycles while enabled
module virgule_timer_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             tick_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign tick_o = enable_i & (cnt_q == prescale_i);
  assign cnt_d = (!enable_i || restart_i || tick_o) ? '0 : cnt_q + WIDTH'(1);
  // Divider count, parked at zero while the timer is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/virgule_timer.sv
// virgule_timer: memory-mapped down-counting timer with prescaler, one-shot/periodic modes and level irq
module virgule_timer
  import virgule_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_valid_i,
  input  logic [31:0] bus_address_i,
  input  logic [3:0]  bus_wstrobe_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_ready_o,
  output logic [31:0] bus_rdata_o,
  output logic        bus_irq_o
);
  timer_ctrl_t               ctrl_q, ctrl_d, ctrl_w;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [COUNT_WIDTH-1:0]    compare_q, compare_d, count_q, count_d;
  logic                      event_q, event_d, irq_q, ready_q;
  logic [31:0]               rdata_q, rd_val;
  logic [2:0]                off;
  logic                      acc, wr, tick, fire, clr, restart;
  logic                      unused_addr;
  assign off = bus_address_i[4:2];
  assign unused_addr = ^{bus_address_i[31:5], bus_address_i[1:0]};
  assign acc = bus_valid_i & ~ready_q;
  assign wr = acc & (|bus_wstrobe_i);
  assign fire = tick & (count_q == '0);
  assign clr = wr & (off == TIMER_STATUS) & bus_wstrobe_i[0] & bus_wdata_i[0];
  assign ctrl_w = timer_ctrl_t'(3'(merge_wstrobe({29'd0, ctrl_q}, bus_wdata_i, bus_wstrobe_i)));
  assign restart = wr & (off == TIMER_CTRL) & ctrl_w.enable & ~ctrl_q.enable;
  // A new event always wins over a simultaneous write-1-clear.
  assign event_d = fire | (event_q & ~clr);
  virgule_timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (ctrl_q.enable),
    .restart_i (restart),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );
  // Read mux over the register map; unmapped offsets read zero.
  always_comb begin
    rd_val = off == TIMER_CTRL     ? {29'd0, ctrl_q} :
             off == TIMER_PRESCALE ? 32'(prescale_q) :
             off == TIMER_COMPARE  ? 32'(compare_q) :
             off == TIMER_COUNT    ? 32'(count_q) :
             off == TIMER_STATUS   ? {31'd0, event_q} : '0;
  end
  // Tick-driven count/auto-disable first, then bus writes override them.
  always_comb begin
    ctrl_d = ctrl_q;
    prescale_d = prescale_q;
    compare_d = compare_q;
    count_d = count_q;
    if (tick) count_d = fire ? (ctrl_q.periodic ? compare_q : count_q) : count_q - COUNT_WIDTH'(1);
    if (fire && !ctrl_q.periodic) ctrl_d.enable = 1'b0;
    if (wr && off == TIMER_CTRL) ctrl_d = ctrl_w;
    if (wr && off == TIMER_PRESCALE)
      prescale_d = PRESCALE_WIDTH'(merge_wstrobe(32'(prescale_q), bus_wdata_i, bus_wstrobe_i));
    if (wr && off == TIMER_COMPARE)
      compare_d = COUNT_WIDTH'(merge_wstrobe(32'(compare_q), bus_wdata_i, bus_wstrobe_i));
    if (wr && off == TIMER_COUNT)
      count_d = COUNT_WIDTH'(merge_wstrobe(32'(count_q), bus_wdata_i, bus_wstrobe_i));
  end
  // Register file, handshake and irq; read data is captured on the acknowledging edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      prescale_q <= '0;
      compare_q <= '0;
      count_q <= '0;
      event_q <= 1'b0;
      irq_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q <= compare_d;
      count_q <= count_d;
      event_q <= event_d;
      irq_q <= event_q & ctrl_q.irq_en;
      ready_q <= acc;
      rdata_q <= acc ? rd_val : '0;
    end
  end
  assign bus_ready_o = ready_q;
  assign bus_rdata_o = rdata_q;
  assign bus_irq_o = irq_q;
endmodule

// File: tb/tb_virgule_timer.sv
// tb_virgule_timer: table vectors, directed corner sequences and random traffic against a reference model
module tb_virgule_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_valid = 1'b0;
  logic [31:0] bus_address = '0;
  logic [3:0]  bus_wstrobe = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ready, bus_irq;
  logic [31:0] bus_rdata;
  int          passed = 0, total = 0, cyc = 0;

  virgule_timer dut (
    .clk          (clk),
    .reset        (reset),
    .bus_valid_i  (bus_valid),
    .bus_address_i(bus_address),
    .bus_wstrobe_i(bus_wstrobe),
    .bus_wdata_i  (bus_wdata),
    .bus_ready_o  (bus_ready),
    .bus_rdata_o  (bus_rdata),
    .bus_irq_o    (bus_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: register file indexed by offset, advanced once per clock.
  typedef struct packed {
    logic [2:0]  ctrl;
    logic [15:0] ps, pc;
    logic [31:0] cmp, cnt;
    logic        ev, irq, rdy;
    logic [31:0] rd;
  } mstate_t;
  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input logic v, input logic [2:0] a,
                                   input logic [3:0] st, input logic [31:0] wd);
    mstate_t n;
    logic [31:0] cur [8];
    logic [31:0] mw;
    logic acc, tick, set;
    n = s;
    cur = '{{29'd0, s.ctrl}, {16'd0, s.ps}, s.cmp, s.cnt, {31'd0, s.ev}, 32'd0, 32'd0, 32'd0};
    acc = v && !s.rdy;
    tick = s.ctrl[0] && s.pc == s.ps;
    set = tick && s.cnt == 32'd0;
    n.irq = s.ev && s.ctrl[1];
    n.rdy = acc;
    n.rd = acc ? cur[a] : 32'd0;
    n.pc = (s.ctrl[0] && !tick) ? s.pc + 16'd1 : 16'd0;
    if (tick && !set) n.cnt = s.cnt - 32'd1;
    if (set && s.ctrl[2]) n.cnt = s.cmp;
    if (set && !s.ctrl[2]) n.ctrl[0] = 1'b0;
    if (set) n.ev = 1'b1;
    if (acc && st != 4'd0) begin
      for (int i = 0; i < 4; i++) mw[8*i+:8] = st[i] ? wd[8*i+:8] : cur[a][8*i+:8];
      case (a)
        3'd0: n.ctrl = mw[2:0];
        3'd1: n.ps = mw[15:0];
        3'd2: n.cmp = mw;
        3'd3: n.cnt = mw;
        3'd4: if (st[0] && wd[0] && !set) n.ev = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else m <= step(m, bus_valid, bus_address[4:2], bus_wstrobe, bus_wdata);
  end

  always @(negedge clk) begin
    chk("model_ready", {31'd0, bus_ready}, {31'd0, m.rdy});
    if (m.rdy) chk("model_rdata", bus_rdata, m.rd);
    chk("model_irq", {31'd0, bus_irq}, {31'd0, m.irq});
  end

  task automatic xfer(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk);
    #1;
    bus_valid = 1'b1;
    bus_address = {27'd0, off, 2'b00};
    bus_wstrobe = strb;
    bus_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ready && n < 8);
    chk("ack", {31'd0, bus_ready}, 32'd1);
    rd = bus_rdata;
    lat = n - 1;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_wstrobe = '0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] r;
    int l;
    xfer(off, 4'hF, d, r, l);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    xfer(off, 4'd0, 32'd0, r, l);
    chk(name, r, exp);
  endtask

  task automatic wait_irq(input int bound, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_irq && k < bound);
    chk("irq_wait", {31'd0, bus_irq}, 32'd1);
  endtask

  task automatic rand_op();
    logic [2:0]  off;
    logic [3:0]  strb;
    logic [31:0] d, r;
    int l;
    if ($urandom_range(0, 15) == 0) begin
      @(posedge clk);
      #1;
      bus_valid = 1'b1;
      bus_address = {27'd0, 3'd3, 2'b00};
      bus_wstrobe = '0;
      repeat (6) @(posedge clk);
      #1;
      bus_valid = 1'b0;
    end else begin
      off = 3'($urandom_range(0, 7));
      strb = $urandom_range(0, 1) == 1 ? 4'($urandom_range(1, 15)) : 4'd0;
      d = off == 3'd1 ? $urandom_range(0, 3) : (off == 3'd2 || off == 3'd3) ? $urandom_range(0, 8) : $urandom;
      xfer(off, strb, d, r, l);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  off;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  initial begin
    logic [31:0] r;
    int l, k, t1, t2;
    tbl = '{
      '{1'b1, 3'd2, 4'hF, 32'h0000_1234, 32'h0},
      '{1'b0, 3'd2, 4'h0, 32'h0, 32'h0000_1234},
      '{1'b1, 3'd2, 4'b0010, 32'hAABB_CCDD, 32'h0},
      '{1'b0, 3'd2, 4'h0, 32'h0, 32'h0000_CC34},
      '{1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF, 32'h0},
      '{1'b0, 3'd6, 4'h0, 32'h0, 32'h0},
      '{1'b0, 3'd2, 4'h0, 32'h0, 32'h0000_CC34},
      '{1'b1, 3'd0, 4'hF, 32'hFFFF_FFF8, 32'h0},
      '{1'b0, 3'd0, 4'h0, 32'h0, 32'h0},
      '{1'b1, 3'd1, 4'b0011, 32'h1234_5678, 32'h0},
      '{1'b0, 3'd1, 4'h0, 32'h0, 32'h0000_5678},
      '{1'b1, 3'd1, 4'hF, 32'h0, 32'h0},
      '{1'b1, 3'd3, 4'b0001, 32'h0000_0007, 32'h0},
      '{1'b0, 3'd3, 4'h0, 32'h0, 32'h0000_0007},
      '{1'b1, 3'd3, 4'hF, 32'h0, 32'h0},
      '{1'b0, 3'd4, 4'h0, 32'h0, 32'h0}
    };
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_irq", {31'd0, bus_irq}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    // Reset while an acknowledged write is on the bus.
    @(posedge clk);
    #1;
    bus_valid = 1'b1;
    bus_address = {27'd0, 3'd2, 2'b00};
    bus_wstrobe = 4'hF;
    bus_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 chk("pre_rst_ready", {31'd0, bus_ready}, 32'd1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_ready", {31'd0, bus_ready}, 32'd0);
    bus_valid = 1'b0;
    bus_wstrobe = '0;
    chk("mid_rst_irq", {31'd0, bus_irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) rd_chk("rst_reg", 3'(i), 32'd0);
    // Register map, lane merging and unmapped offsets.
    for (int i = 0; i < 16; i++) begin
      xfer(tbl[i].off, tbl[i].wr ? tbl[i].strb : 4'd0, tbl[i].data, r, l);
      chk("latency", 32'(l), 32'd1);
      if (!tbl[i].wr) chk("table_rdata", r, tbl[i].exp);
    end
    // One-shot: four ticks to the event, then irq one cycle later.
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd3);
    wr(3'd0, 32'd3);
    wait_irq(20, k);
    chk("oneshot_delay", 32'(k), 32'd5);
    rd_chk("oneshot_ctrl", 3'd0, 32'd2);
    rd_chk("oneshot_count", 3'd3, 32'd0);
    rd_chk("oneshot_status", 3'd4, 32'd1);
    repeat (5) @(posedge clk);
    rd_chk("oneshot_count_hold", 3'd3, 32'd0);
    wr(3'd4, 32'd1);
    @(negedge clk);
    chk("irq_cleared", {31'd0, bus_irq}, 32'd0);
    // Periodic: 3 ticks of 5 cycles between events.
    wr(3'd1, 32'd4);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd7);
    wait_irq(40, k);
    t1 = cyc;
    rd_chk("periodic_reload", 3'd3, 32'd2);
    wr(3'd4, 32'd1);
    wait_irq(40, k);
    t2 = cyc;
    chk("periodic_period", 32'(t2 - t1), 32'd15);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    // Collisions: event every cycle, so the clear always meets a new event.
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd7);
    wait_irq(10, k);
    wr(3'd4, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("collide_irq", {31'd0, bus_irq}, 32'd1);
    end
    rd_chk("collide_status", 3'd4, 32'd1);
    wr(3'd3, 32'd9);
    rd_chk("count_write_on_tick", 3'd3, 32'd7);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    // Random traffic against the model, with one asynchronous reset in the middle.
    for (int t = 0; t < 300; t++) begin
      if (t == 150) begin
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
      rand_op();
    end
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
